// File: rtl/obi_mp_ram_if.sv
// Bus bundle for obi_mp_ram: per-port OBI request/grant/response signals, packed port-major.
// Port p occupies bit p of the 1-bit vectors and [32p+31:32p] / [4p+3:4p] of the wide ones.
interface obi_mp_ram_if #(
    parameter int NUM_PORTS = 3
);
    logic [NUM_PORTS-1:0]    req_i;
    logic [NUM_PORTS-1:0]    gnt_o;
    logic [NUM_PORTS*32-1:0] addr_i;
    logic [NUM_PORTS-1:0]    we_i;
    logic [NUM_PORTS*4-1:0]  be_i;
    logic [NUM_PORTS*32-1:0] wdata_i;
    logic [NUM_PORTS-1:0]    rvalid_o;
    logic [NUM_PORTS*32-1:0] rdata_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/obi_mp_ram.sv
// Multi-port OBI test RAM: round-robin arbiter, single-ported word RAM, MMIO pass/fail/exit window.
// Optional grant stalling through an LFSR is enabled by defining OBI_MP_RAM_RANDOM_STALL_EN.
module obi_mp_ram #(
    parameter int          NUM_PORTS      = 3,
    parameter int          RAM_ADDR_WIDTH = 20,
    parameter int          LATENCY        = 1,
    parameter logic [31:0] MMIO_BASE      = 32'h2000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    obi_mp_ram_if.slave        bus,
    output logic               tests_passed_o,
    output logic               tests_failed_o,
    output logic [31:0]        exit_value_o,
    output logic               exit_valid_o
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int WORD_W = RAM_ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** WORD_W;

    logic [IDX_W-1:0]     r_ptr;
    logic                 w_stall;
    logic [NUM_PORTS-1:0] w_gnt;
    logic                 w_gntValid;
    logic [IDX_W-1:0]     w_gntIdx;
    logic [IDX_W:0]       w_sum;
    logic [IDX_W-1:0]     w_nextPtr;
    logic [31:0]          w_addr;
    logic [31:0]          w_wdata;
    logic [3:0]           w_be;
    logic                 w_we;
    logic                 w_isMmio;
    logic [WORD_W-1:0]    w_word;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    logic [31:0]          r_mem [DEPTH];
    logic [LATENCY-1:0]   r_pipeValid;
    logic [IDX_W-1:0]     r_pipeIdx  [LATENCY];
    logic [31:0]          r_pipeData [LATENCY];
    logic                 r_testsPassed;
    logic                 r_testsFailed;
    logic [31:0]          r_exitValue;
    logic                 r_exitValid;

`ifdef OBI_MP_RAM_RANDOM_STALL_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR, taps 16,14,13,11; a zero in the two low bits blocks every grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // Scan ports starting at the priority pointer; first requester wins.
    always_comb begin
        w_gnt      = '0;
        w_gntValid = 1'b0;
        w_gntIdx   = '0;
        w_sum      = '0;
        if (!rst_i && !w_stall) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_sum = {1'b0, r_ptr} + (IDX_W+1)'(i);
                if (w_sum >= (IDX_W+1)'(NUM_PORTS)) begin
                    w_sum = w_sum - (IDX_W+1)'(NUM_PORTS);
                end
                if (!w_gntValid && bus.req_i[w_sum[IDX_W-1:0]]) begin
                    w_gntValid = 1'b1;
                    w_gntIdx   = w_sum[IDX_W-1:0];
                end
            end
        end
        if (w_gntValid) begin
            w_gnt[w_gntIdx] = 1'b1;
        end
    end

    assign bus.gnt_o = w_gnt;
    assign w_nextPtr = (w_gntIdx == IDX_W'(NUM_PORTS - 1)) ? '0 : w_gntIdx + 1'b1;

    assign w_addr   = bus.addr_i[32*w_gntIdx +: 32];
    assign w_wdata  = bus.wdata_i[32*w_gntIdx +: 32];
    assign w_be     = bus.be_i[4*w_gntIdx +: 4];
    assign w_we     = bus.we_i[w_gntIdx];
    assign w_isMmio = (w_addr[31:12] == MMIO_BASE[31:12]);
    assign w_word   = w_addr[RAM_ADDR_WIDTH-1:2];
    assign w_rdata  = (w_we || w_isMmio) ? 32'd0 : r_mem[w_word];
    assign w_unused = ^w_addr[1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (w_gntValid) begin
            r_ptr <= w_nextPtr;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (w_gntValid && w_we && !w_isMmio) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_word][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_testsPassed <= 1'b0;
            r_testsFailed <= 1'b0;
            r_exitValue   <= '0;
            r_exitValid   <= 1'b0;
        end else if (w_gntValid && w_we && w_isMmio) begin
            case (w_addr[11:2])
                10'd1: begin
                    if (w_wdata == 32'd123456789) begin
                        r_testsPassed <= 1'b1;
                    end else if (w_wdata == 32'd1) begin
                        r_testsFailed <= 1'b1;
                    end
                end
                10'd2: begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_be[b]) begin
                            r_exitValue[8*b +: 8] <= w_wdata[8*b +: 8];
                        end
                    end
                    r_exitValid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pipeValid <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_pipeIdx[k]  <= '0;
                r_pipeData[k] <= '0;
            end
        end else begin
            r_pipeValid[0] <= w_gntValid;
            r_pipeIdx[0]   <= w_gntIdx;
            r_pipeData[0]  <= w_gntValid ? w_rdata : 32'd0;
            for (int k = 1; k < LATENCY; k++) begin
                r_pipeValid[k] <= r_pipeValid[k-1];
                r_pipeIdx[k]   <= r_pipeIdx[k-1];
                r_pipeData[k]  <= r_pipeData[k-1];
            end
        end
    end

    always_comb begin
        bus.rvalid_o = '0;
        bus.rdata_o  = '0;
        if (r_pipeValid[LATENCY-1]) begin
            bus.rvalid_o[r_pipeIdx[LATENCY-1]]        = 1'b1;
            bus.rdata_o[32*r_pipeIdx[LATENCY-1] +: 32] = r_pipeData[LATENCY-1];
        end
    end

    assign tests_passed_o = r_testsPassed;
    assign tests_failed_o = r_testsFailed;
    assign exit_value_o   = r_exitValue;
    assign exit_valid_o   = r_exitValid;
endmodule

// File: tb/tb_obi_mp_ram.sv
// Directed bench for obi_mp_ram: table of single transactions plus hand-written
// sequences for back-to-back hazards, reset mid-flight, round-robin and grant stalling.
module tb_obi_mp_ram;
    localparam int          NP   = 3;
    localparam int          LAT  = 3;
    localparam logic [31:0] MMIO = 32'h2000_0000;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expPass;
        logic        expFail;
        logic        expExitValid;
        logic [31:0] expExit;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        testsPassed;
    logic        testsFailed;
    logic [31:0] exitValue;
    logic        exitValid;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[$];

    obi_mp_ram_if #(.NUM_PORTS(NP)) bus ();

    obi_mp_ram #(
        .NUM_PORTS(NP), .RAM_ADDR_WIDTH(20), .LATENCY(LAT), .MMIO_BASE(MMIO)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .bus            (bus),
        .tests_passed_o (testsPassed),
        .tests_failed_o (testsFailed),
        .exit_value_o   (exitValue),
        .exit_valid_o   (exitValid)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog act=timeout req=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input int p, input logic we, input logic [31:0] a, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] rd, input logic ps, input logic fl,
                                input logic xv, input logic [31:0] xd);
        vec_t v;
        v.port = p; v.we = we; v.addr = a; v.be = be; v.wdata = wd; v.expRdata = rd;
        v.expPass = ps; v.expFail = fl; v.expExitValid = xv; v.expExit = xd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s act=0x%08h req=0x%08h", name, act, exp);
        end
    endtask

    task automatic driveReq(input int port, input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata);
        bus.req_i[port]             = 1'b1;
        bus.we_i[port]              = we;
        bus.addr_i[32*port +: 32]   = addr;
        bus.be_i[4*port +: 4]       = be;
        bus.wdata_i[32*port +: 32]  = wdata;
    endtask

    task automatic waitGrant(input int port, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (bus.gnt_o[port]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
        end
    endtask

    // One transaction: returns grant seen, grant-to-rvalid latency, read data, and rvalid one cycle later.
    task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr, input logic [3:0] be,
                                 input logic [31:0] wdata, output bit gotGnt, output int lat,
                                 output logic [31:0] rd, output logic extra);
        @(posedge clk_i); #1;
        driveReq(port, we, addr, be, wdata);
        waitGrant(port, gotGnt);
        @(posedge clk_i); #1;
        bus.req_i[port] = 1'b0;
        lat = -1;
        rd = '0;
        extra = 1'b0;
        if (gotGnt) begin
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk_i);
                if (bus.rvalid_o[port]) begin
                    lat = c;
                    rd = bus.rdata_o[32*port +: 32];
                    break;
                end
            end
            @(negedge clk_i);
            extra = bus.rvalid_o[port];
        end
    endtask

    initial begin
        bit          ok;
        int          lat;
        logic [31:0] rd;
        logic        extra;
        int          rvCnt [NP];
        int          grants;
        int          stalls;
        int          rvs;

        bus.req_i = '1; bus.we_i = '0; bus.addr_i = '0; bus.be_i = '1; bus.wdata_i = '0;
        rst_i = 1'b1;

        // Reset with every port requesting: no grants, everything idle.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_gnt", 32'(bus.gnt_o), 32'd0);
        checkOutput("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
        checkOutput("rst_rdata", bus.rdata_o[31:0] | bus.rdata_o[63:32] | bus.rdata_o[95:64], 32'd0);
        checkOutput("rst_pass", 32'(testsPassed), 32'd0);
        checkOutput("rst_fail", 32'(testsFailed), 32'd0);
        checkOutput("rst_exitv", 32'(exitValid), 32'd0);
        checkOutput("rst_exit", exitValue, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        bus.req_i = '0;

        vecs.push_back(mk(1, 1, 32'h0000_0100, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0000_0100, 4'hF, 0, 32'hDEADBEEF, 0, 0, 0, 0));
        vecs.push_back(mk(2, 1, 32'h0000_0040, 4'hF, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 32'h0000_0040, 4'b0011, 32'h11223344, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0000_0040, 4'hF, 0, 32'h00003344, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 32'h0010_0100, 4'hF, 0, 32'hDEADBEEF, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0000_0103, 4'hF, 0, 32'hDEADBEEF, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_0104, 4'hF, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 1, 32'h0000_0104, 4'b1100, 32'hAABBCCDD, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0000_0104, 4'hF, 0, 32'hAABB0000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, MMIO + 32'h100, 4'hF, 32'h12345678, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 32'h0000_0100, 4'hF, 0, 32'hDEADBEEF, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, MMIO + 32'h4, 4'hF, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, MMIO + 32'h4, 4'hF, 32'd123456789, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, MMIO + 32'h8, 4'hF, 32'h2A, 0, 1, 0, 1, 32'h2A));
        vecs.push_back(mk(2, 1, MMIO + 32'h4, 4'hF, 32'd5, 0, 1, 0, 1, 32'h2A));
        vecs.push_back(mk(0, 1, MMIO + 32'h8, 4'b0010, 32'hFFFFFFFF, 0, 1, 0, 1, 32'h0000FF2A));
        vecs.push_back(mk(2, 1, MMIO + 32'hC, 4'hF, 32'd1, 0, 1, 0, 1, 32'h0000FF2A));
        vecs.push_back(mk(1, 1, MMIO + 32'h4, 4'hF, 32'd1, 0, 1, 1, 1, 32'h0000FF2A));
        vecs.push_back(mk(0, 1, MMIO + 32'h0, 4'hF, 32'h41, 0, 1, 1, 1, 32'h0000FF2A));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, ok, lat, rd, extra);
            checkOutput($sformatf("v%0d_gnt", i), 32'(ok), 32'd1);
            checkOutput($sformatf("v%0d_lat", i), 32'(lat), 32'(LAT));
            checkOutput($sformatf("v%0d_rdata", i), rd, vecs[i].expRdata);
            checkOutput($sformatf("v%0d_pulse", i), 32'(extra), 32'd0);
            checkOutput($sformatf("v%0d_pass", i), 32'(testsPassed), 32'(vecs[i].expPass));
            checkOutput($sformatf("v%0d_fail", i), 32'(testsFailed), 32'(vecs[i].expFail));
            checkOutput($sformatf("v%0d_exitv", i), 32'(exitValid), 32'(vecs[i].expExitValid));
            checkOutput($sformatf("v%0d_exit", i), exitValue, vecs[i].expExit);
        end

        // Write on port 1 then read of the same word on port 2 the very next grant.
        @(posedge clk_i); #1;
        driveReq(1, 1'b1, 32'h0000_0300, 4'hF, 32'hCAFEF00D);
        waitGrant(1, ok);
        checkOutput("raw_wgnt", 32'(ok), 32'd1);
        @(posedge clk_i); #1;
        bus.req_i[1] = 1'b0;
        driveReq(2, 1'b0, 32'h0000_0300, 4'hF, 32'h0);
        waitGrant(2, ok);
        checkOutput("raw_rgnt", 32'(ok), 32'd1);
        @(posedge clk_i); #1;
        bus.req_i[2] = 1'b0;
        rd = '0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_i);
            if (bus.rvalid_o[2]) begin
                rd = bus.rdata_o[64 +: 32];
                lat = c;
                break;
            end
        end
        checkOutput("raw_lat", 32'(lat), 32'(LAT));
        checkOutput("raw_rdata", rd, 32'hCAFEF00D);
        repeat (LAT + 2) @(negedge clk_i);

        // Read granted on port 0, then reset one cycle later: the response must vanish.
        @(posedge clk_i); #1;
        driveReq(0, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
        waitGrant(0, ok);
        checkOutput("midrst_gnt", 32'(ok), 32'd1);
        @(posedge clk_i); #1;
        bus.req_i[0] = 1'b0;
        rst_i = 1'b1;
        rvs = 0;
        @(negedge clk_i);
        rvs += $countones(bus.rvalid_o);
        @(posedge clk_i); #1;
        bus.req_i = '1;
        bus.we_i = '0;
        @(negedge clk_i);
        checkOutput("midrst_gnt_forced", 32'(bus.gnt_o), 32'd0);
        rvs += $countones(bus.rvalid_o);
        @(posedge clk_i); #1;
        bus.req_i = '0;
        rst_i = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            rvs += $countones(bus.rvalid_o);
        end
        checkOutput("midrst_no_rvalid", 32'(rvs), 32'd0);
        checkOutput("midrst_pass", 32'(testsPassed), 32'd0);
        checkOutput("midrst_fail", 32'(testsFailed), 32'd0);
        checkOutput("midrst_exitv", 32'(exitValid), 32'd0);
        checkOutput("midrst_exit", exitValue, 32'd0);

`ifndef OBI_MP_RAM_RANDOM_STALL_EN
        // All ports requesting from a fresh pointer: strict 0,1,2 rotation, RAM survived reset.
        foreach (rvCnt[p]) rvCnt[p] = 0;
        @(posedge clk_i); #1;
        for (int p = 0; p < NP; p++) driveReq(p, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
        for (int i = 0; i < 6 + LAT + 2; i++) begin
            @(negedge clk_i);
            if (i < 6) checkOutput($sformatf("rr_gnt%0d", i), 32'(bus.gnt_o), 32'(1 << (i % NP)));
            for (int p = 0; p < NP; p++) begin
                if (bus.rvalid_o[p]) begin
                    rvCnt[p]++;
                    checkOutput($sformatf("rr_rdata_p%0d", p), bus.rdata_o[32*p +: 32], 32'hDEADBEEF);
                end
            end
            @(posedge clk_i); #1;
            if (i == 5) bus.req_i = '0;
        end
        for (int p = 0; p < NP; p++) checkOutput($sformatf("rr_rvcnt_p%0d", p), 32'(rvCnt[p]), 32'd2);
`else
        // Back-to-back requests on port 0 under random stalls: every one granted and answered once.
        grants = 0;
        stalls = 0;
        rvs = 0;
        @(posedge clk_i); #1;
        driveReq(0, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
        for (int c = 0; c < 4000 && grants < 1000; c++) begin
            @(negedge clk_i);
            if (bus.gnt_o[0]) grants++;
            else stalls++;
            if (bus.rvalid_o[0]) rvs++;
            @(posedge clk_i); #1;
            if (grants == 1000) bus.req_i[0] = 1'b0;
        end
        repeat (LAT + 3) begin
            @(negedge clk_i);
            if (bus.rvalid_o[0]) rvs++;
        end
        checkOutput("stall_grants", 32'(grants), 32'd1000);
        checkOutput("stall_rvalids", 32'(rvs), 32'd1000);
        checkOutput("stall_rate_ok", 32'(stalls >= 200 && stalls <= 500), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
